// File: rtl/cic_downsampler.sv
// cic_downsampler: forwards one of every R integrator samples to the comb chain,
// with runtime-selectable R, sticky overrun and rate-error flags.
module cic_downsampler #(
  parameter int WordLengthBits = 29,
  parameter int MaxRate        = 64,
  parameter int RateBits       = $clog2(MaxRate + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RateBits-1:0]       rate,
  input  logic [WordLengthBits-1:0] in,
  input  logic                      in_valid,
  input  logic                      out_ready,
  output logic [WordLengthBits-1:0] out,
  output logic                      out_valid,
  output logic                      overrun,
  output logic                      rate_err
);
  localparam logic [RateBits-1:0] MaxR = RateBits'(MaxRate);
  logic [WordLengthBits-1:0] out_q, out_d;
  logic [RateBits-1:0]       phase_q, phase_d, active_q, active_d, rate_map, eff;
  logic                      out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                      rate_err_q, rate_err_d, first_q, first_d;
  logic                      rate_hi, emit, load;
  always_comb begin
    rate_hi     = rate > MaxR;
    rate_map    = rate_hi ? MaxR : (rate < RateBits'(2) ? RateBits'(1) : rate);
    // The first clock after reset already runs with the freshly loaded rate.
    eff         = first_q ? rate_map : active_q;
    emit        = in_valid && (phase_q == eff - RateBits'(1));
    load        = first_q || emit;
    phase_d     = emit ? '0 : (in_valid ? phase_q + RateBits'(1) : phase_q);
    active_d    = load ? rate_map : active_q;
    first_d     = 1'b0;
    rate_err_d  = rate_err_q || (load && rate_hi);
    out_d       = emit ? in : out_q;
    out_valid_d = emit || (out_valid_q && !out_ready);
    overrun_d   = overrun_q || (emit && out_valid_q && !out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      rate_err_q  <= 1'b0;
      phase_q     <= '0;
      active_q    <= RateBits'(1);
      first_q     <= 1'b1;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      rate_err_q  <= rate_err_d;
      phase_q     <= phase_d;
      active_q    <= active_d;
      first_q     <= first_d;
    end
  end
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign rate_err  = rate_err_q;
endmodule

// File: tb/tb_cic_downsampler.sv
// tb_cic_downsampler: frame-counting reference model feeds an expected-word queue;
// a negedge monitor compares and pops as the comb side consumes.
module tb_cic_downsampler;
  localparam int W = 29, MAXR = 64, RB = $clog2(MAXR + 1);
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [RB-1:0] rate = 4;
  logic [W-1:0] in_data = '0, out;
  logic out_valid, overrun, rate_err;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_q[$];
  bit pend, ovr, rerr, first;
  int cnt, r_act, seqv;
  cic_downsampler #(.WordLengthBits(W), .MaxRate(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .rate(rate), .in(in_data), .in_valid(in_valid),
    .out_ready(out_ready), .out(out), .out_valid(out_valid), .overrun(overrun),
    .rate_err(rate_err));
  always #5 clk = ~clk;
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int mapr(int r);
    return r <= 1 ? 1 : (r > MAXR ? MAXR : r);
  endfunction
  task automatic model_clear();
    exp_q.delete();
    pend = 0; ovr = 0; rerr = 0; first = 1; cnt = 0; r_act = 1;
  endtask
  // Reference: count valid samples; the R-th of each frame becomes the next word.
  task automatic model_step();
    int eff;
    bit emit;
    eff = first ? mapr(int'(rate)) : r_act;
    emit = 0;
    if (in_valid) begin
      cnt++;
      if (cnt >= eff) begin emit = 1; cnt = 0; end
    end
    if (first || emit) begin
      r_act = mapr(int'(rate));
      if (int'(rate) > MAXR) rerr = 1;
    end
    first = 0;
    if (emit) begin
      if (pend && !out_ready) begin
        ovr = 1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      exp_q.push_back(in_data);
      pend = 1;
    end else if (out_ready) pend = 0;
  endtask
  always @(negedge clk) begin
    chk("out_valid", out_valid, pend);
    chk("overrun", overrun, ovr);
    chk("rate_err", rate_err, rerr);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
      else chk("out", out, exp_q[0]);
    end
    if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end
  task automatic cycle(bit v, logic [W-1:0] d, bit rdy);
    in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask
  task automatic seg(int n, int r, int pv, int pr, bit seq);
    rate = RB'(r);
    for (int i = 0; i < n; i++) begin
      bit v;
      v = $urandom_range(99) < pv;
      if (v && seq) seqv++;
      cycle(v, seq ? W'(seqv) : W'($urandom), $urandom_range(99) < pr);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0; in_valid = 0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rate_err", rate_err, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1;
  endtask
  initial begin
    model_clear();
    seqv = 0;
    #23 rst_n = 1;
    seg(20, 4, 100, 100, 1);
    seg(6, 1, 100, 100, 1);
    seg(24, 3, 50, 100, 1);
    seg(12, 2, 100, 0, 1);
    seg(8, 2, 100, 50, 1);
    seg(6, 4, 100, 0, 1);
    do_reset();
    seqv = 0;
    seg(12, 4, 100, 100, 1);
    seg(2, 4, 100, 100, 1);
    seg(12, 2, 100, 100, 1);
    seg(200, MAXR + 5, 100, 100, 0);
    do_reset();
    for (int k = 0; k < 30; k++) seg(20, $urandom_range(MAXR + 6), $urandom_range(30, 100), $urandom_range(100), 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
